// File: rtl/reg_bus_pkg.sv
// Shared encodings for the register-bus sequencer: opcodes, FSM states,
// bus-source selects and the latched instruction layout.
package reg_bus_pkg;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SWAP = 3'b100
    } op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        DONE = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_R0   = 3'd1,
        SRC_R1   = 3'd2,
        SRC_R2   = 3'd3,
        SRC_R3   = 3'd4,
        SRC_DIN  = 3'd5,
        SRC_G    = 3'd6,
        SRC_TMP  = 3'd7
    } src_e;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] rx;
        logic [1:0] ry;
    } ir_t;

    function automatic src_e reg_src(input logic [1:0] idx);
        case (idx)
            2'd0:    return SRC_R0;
            2'd1:    return SRC_R1;
            2'd2:    return SRC_R2;
            default: return SRC_R3;
        endcase
    endfunction

    function automatic logic is_long(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SWAP);
    endfunction

endpackage

// File: rtl/reg_bus_datapath.sv
// Register file R0..R3 plus A/G/TMP and the single shared bus; every
// register write takes its value from the bus except G, which takes A +/- bus.
module reg_bus_datapath
    import reg_bus_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  src_e                  src,
    input  logic [DATA_W-1:0]     din,
    input  logic [3:0]            ld_r,
    input  logic                  ld_a,
    input  logic                  ld_g,
    input  logic                  ld_tmp,
    input  logic                  sub,
    output logic [DATA_W-1:0]     bus,
    output logic [4*DATA_W-1:0]   regs
);

    logic [3:0][DATA_W-1:0] r;
    logic [DATA_W-1:0]      a, g, tmp;

    always_comb begin
        bus = '0;
        case (src)
            SRC_R0:  bus = r[0];
            SRC_R1:  bus = r[1];
            SRC_R2:  bus = r[2];
            SRC_R3:  bus = r[3];
            SRC_DIN: bus = din;
            SRC_G:   bus = g;
            SRC_TMP: bus = tmp;
            default: bus = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r   <= '0;
            a   <= '0;
            g   <= '0;
            tmp <= '0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (ld_r[i]) r[i] <= bus;
            if (ld_a)   a   <= bus;
            if (ld_g)   g   <= sub ? (a - bus) : (a + bus);
            if (ld_tmp) tmp <= bus;
        end
    end

    assign regs = r;

endmodule

// File: rtl/reg_bus_sequencer.sv
// Multi-cycle register-transfer controller: FSM, instruction register and
// per-step control decode driving reg_bus_datapath.
module reg_bus_sequencer
    import reg_bus_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [1:0]            rx,
    input  logic [1:0]            ry,
    input  logic [DATA_W-1:0]     din,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_W-1:0]     bus,
    output logic [4*DATA_W-1:0]   regs
);

    state_e            state;
    ir_t               ir;
    logic [DATA_W-1:0] ir_din;

    src_e       src;
    logic [3:0] ld_r;
    logic       ld_a, ld_g, ld_tmp, sub;

    // DONE behaves like IDLE for command acceptance, so back-to-back
    // instructions lose no cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ir     <= '0;
            ir_din <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        ir     <= '{op: op, rx: rx, ry: ry};
                        ir_din <= din;
                        state  <= T1;
                        busy   <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end
                end
                T1: begin
                    if (is_long(ir.op)) begin
                        state <= T2;
                    end else begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                T2: state <= T3;
                T3: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        src    = SRC_NONE;
        ld_r   = '0;
        ld_a   = 1'b0;
        ld_g   = 1'b0;
        ld_tmp = 1'b0;
        sub    = (ir.op == OP_SUB);
        case (state)
            T1: case (ir.op)
                OP_MV:   begin src = reg_src(ir.ry); ld_r[ir.rx] = 1'b1; end
                OP_MVI:  begin src = SRC_DIN;        ld_r[ir.rx] = 1'b1; end
                OP_ADD,
                OP_SUB:  begin src = reg_src(ir.rx); ld_a = 1'b1; end
                OP_SWAP: begin src = reg_src(ir.ry); ld_tmp = 1'b1; end
                default: src = SRC_NONE;
            endcase
            T2: case (ir.op)
                OP_ADD,
                OP_SUB:  begin src = reg_src(ir.ry); ld_g = 1'b1; end
                OP_SWAP: begin src = reg_src(ir.rx); ld_r[ir.ry] = 1'b1; end
                default: src = SRC_NONE;
            endcase
            T3: case (ir.op)
                OP_ADD,
                OP_SUB:  begin src = SRC_G;   ld_r[ir.rx] = 1'b1; end
                OP_SWAP: begin src = SRC_TMP; ld_r[ir.rx] = 1'b1; end
                default: src = SRC_NONE;
            endcase
            default: src = SRC_NONE;
        endcase
    end

    reg_bus_datapath #(.DATA_W(DATA_W)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .src    (src),
        .din    (ir_din),
        .ld_r   (ld_r),
        .ld_a   (ld_a),
        .ld_g   (ld_g),
        .ld_tmp (ld_tmp),
        .sub    (sub),
        .bus    (bus),
        .regs   (regs)
    );

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Scoreboard bench: the driver predicts each instruction's result and done
// cycle from a plain register-array model; a monitor checks every cycle.
module tb_reg_bus_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [1:0]  rx = '0, ry = '0;
    logic [7:0]  din = '0;
    logic        busy, done;
    logic [7:0]  bus;
    logic [31:0] regs;

    reg_bus_sequencer #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rx(rx), .ry(ry),
        .din(din), .busy(busy), .done(done), .bus(bus), .regs(regs)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] regs;
        int          cyc;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m[4];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         acc_cyc = -100;
    int         acc_lat = 0;
    bit         t3_chk = 0;
    logic [7:0] t3_bus = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] model_regs();
        return {m[3], m[2], m[1], m[0]};
    endfunction

    // Issue at a cycle where the DUT is known (from the model) to accept.
    task automatic issue(input logic [2:0] o, input logic [1:0] x, input logic [1:0] y,
                         input logic [7:0] d, input bit spur, input int gap);
        int lat;
        logic [7:0] t;
        lat    = (o == 3'd2 || o == 3'd3 || o == 3'd4) ? 4 : 2;
        t3_chk = (lat == 4);
        case (o)
            3'd0: m[x] = m[y];
            3'd1: m[x] = d;
            3'd2: begin m[x] = m[x] + m[y]; t3_bus = m[x]; end
            3'd3: begin m[x] = m[x] - m[y]; t3_bus = m[x]; end
            3'd4: begin t = m[y]; m[y] = m[x]; m[x] = t; t3_bus = t; end
            default: ;
        endcase
        sb.push_back('{regs: model_regs(), cyc: cyc + lat});
        acc_cyc = cyc;
        acc_lat = lat;
        start = 1'b1; op = o; rx = x; ry = y; din = d;
        @(negedge clk);
        if (spur) begin
            op = 3'd1; rx = x ^ 2'd1; din = ~d;
            @(negedge clk);
        end
        start = 1'b0;
        for (int k = 0; k < 8 && cyc < acc_cyc + lat + gap; k++) @(negedge clk);
    endtask

    // Monitor: sampled just after the falling edge, away from driver updates.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                bit eb;
                eb = (cyc > acc_cyc) && (cyc < acc_cyc + acc_lat);
                chk("busy", {31'd0, busy}, {31'd0, eb});
                if (!eb) chk("bus_idle", {24'd0, bus}, 32'd0);
                if (t3_chk && cyc == acc_cyc + 3) chk("bus_t3", {24'd0, bus}, {24'd0, t3_bus});
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("done_cycle", cyc, e.cyc);
                        chk("regs_at_done", regs, e.regs);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) m[i] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_regs", regs, 32'd0);
        chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
        chk("reset_bus", {24'd0, bus}, 32'd0);
        @(negedge clk);

        // directed scenarios
        issue(3'd1, 2'd1, 2'd0, 8'h3C, 0, 1);
        issue(3'd1, 2'd1, 2'd0, 8'h05, 0, 0);
        issue(3'd1, 2'd2, 2'd0, 8'h03, 0, 0);
        issue(3'd2, 2'd1, 2'd2, 8'h00, 1, 1);   // second start during ADD busy
        issue(3'd1, 2'd0, 2'd0, 8'h02, 0, 0);
        issue(3'd1, 2'd3, 2'd0, 8'h05, 0, 0);
        issue(3'd3, 2'd0, 2'd3, 8'h00, 0, 0);   // 02-05 wraps to FD
        issue(3'd1, 2'd1, 2'd0, 8'hAA, 0, 0);
        issue(3'd1, 2'd2, 2'd0, 8'h55, 0, 0);
        issue(3'd4, 2'd1, 2'd2, 8'h00, 0, 2);
        issue(3'd7, 2'd0, 2'd1, 8'hFF, 0, 1);
        issue(3'd2, 2'd3, 2'd3, 8'h00, 0, 0);   // doubles R3
        issue(3'd3, 2'd2, 2'd2, 8'h00, 0, 0);
        issue(3'd4, 2'd1, 2'd1, 8'h00, 0, 1);
        issue(3'd0, 2'd0, 2'd0, 8'h00, 0, 1);

        for (int n = 0; n < 150; n++)
            issue(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 8'($urandom),
                  1'($urandom), $urandom_range(0, 2));

        // abort an ADD in T2: nothing written, no done, idle afterwards
        issue(3'd1, 2'd1, 2'd0, 8'h11, 0, 1);
        acc_cyc = cyc; acc_lat = 4; t3_chk = 0;
        start = 1'b1; op = 3'd2; rx = 2'd1; ry = 2'd1; din = 8'h00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        acc_lat = 0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m[i] = '0;
        #1;
        chk("abort_regs", regs, 32'd0);
        chk("abort_busy_done", {30'd0, busy, done}, 32'd0);
        repeat (4) @(negedge clk);
        issue(3'd1, 2'd2, 2'd0, 8'h77, 0, 2);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
